axi4_protocol_monitor: RTL

Synthesisable, parametrised AXI4 manager-port protocol monitor. It is instantiated beside an AXI4 manager and passively observes all five channels. It checks handshake stability, payload stability, burst-length and LAST consistency, and response ordering, and reports violations in sticky error flags plus an interrupt. It is the in-silicon successor of the team's simulation-only assertion set, with configurable bus widths and outstanding-transaction depth.

---
 rtl/axi4_protocol_monitor.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_protocol_monitor.sv
// Passive AXI4 manager-port protocol monitor: handshake/payload stability, burst LAST
// consistency and response ordering, reported as sticky flags. Optional stall timeout: AXI_MON_TIMEOUT_EN.
module axi4_protocol_monitor #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                                   M_AXI_ACLK,
    input  logic                                   M_AXI_ARESET,
    input  logic [ADDR_WIDTH-1:0]                  M_AXI_AWADDR,
    input  logic [7:0]                             M_AXI_AWLEN,
    input  logic [2:0]                             M_AXI_AWSIZE,
    input  logic [1:0]                             M_AXI_AWBURST,
    input  logic [2:0]                             M_AXI_AWPROT,
    input  logic                                   M_AXI_AWVALID,
    input  logic                                   M_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                  M_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]                M_AXI_WSTRB,
    input  logic                                   M_AXI_WLAST,
    input  logic                                   M_AXI_WVALID,
    input  logic                                   M_AXI_WREADY,
    input  logic [1:0]                             M_AXI_BRESP,
    input  logic                                   M_AXI_BVALID,
    input  logic                                   M_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]                  M_AXI_ARADDR,
    input  logic [7:0]                             M_AXI_ARLEN,
    input  logic [2:0]                             M_AXI_ARSIZE,
    input  logic [1:0]                             M_AXI_ARBURST,
    input  logic [2:0]                             M_AXI_ARPROT,
    input  logic                                   M_AXI_ARVALID,
    input  logic                                   M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]                  M_AXI_RDATA,
    input  logic [1:0]                             M_AXI_RRESP,
    input  logic                                   M_AXI_RLAST,
    input  logic                                   M_AXI_RVALID,
    input  logic                                   M_AXI_RREADY,
    input  logic                                   mon_err_clr,
    output logic [16:0]                            mon_err,
    output logic [4:0]                             mon_err_first,
    output logic                                   mon_irq,
    output logic [$clog2(MAX_OUTSTANDING+1):0]     mon_wr_outstanding,
    output logic [$clog2(MAX_OUTSTANDING+1):0]     mon_rd_outstanding
);

    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int OW  = CW + 1;
    localparam int PW  = $clog2(MAX_OUTSTANDING);
    localparam int AXW = ADDR_WIDTH + 16;
    localparam int WW  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int RW  = DATA_WIDTH + 3;

    if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0)
        $error("MAX_OUTSTANDING must be a power of 2 and at least 2");
    if (TIMEOUT_CYCLES < 1)
        $error("TIMEOUT_CYCLES must be at least 1");

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    assign w_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
    assign w_b_hs  = M_AXI_BVALID  && M_AXI_BREADY;
    assign w_ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign w_r_hs  = M_AXI_RVALID  && M_AXI_RREADY;

    logic [AXW-1:0] w_ar_pay, w_aw_pay, r_ar_pay, r_aw_pay;
    logic [WW-1:0]  w_w_pay, r_w_pay;
    logic [RW-1:0]  w_r_pay, r_r_pay;
    logic [1:0]     r_b_pay;
    logic           r_ar_pend, r_aw_pend, r_w_pend, r_r_pend, r_b_pend;

    assign w_ar_pay = {M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARPROT};
    assign w_aw_pay = {M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWPROT};
    assign w_w_pay  = {M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST};
    assign w_r_pay  = {M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_ar_pend <= 1'b0;
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_r_pend  <= 1'b0;
            r_b_pend  <= 1'b0;
            r_ar_pay  <= '0;
            r_aw_pay  <= '0;
            r_w_pay   <= '0;
            r_r_pay   <= '0;
            r_b_pay   <= '0;
        end else begin
            r_ar_pend <= M_AXI_ARVALID && !M_AXI_ARREADY;
            r_aw_pend <= M_AXI_AWVALID && !M_AXI_AWREADY;
            r_w_pend  <= M_AXI_WVALID  && !M_AXI_WREADY;
            r_r_pend  <= M_AXI_RVALID  && !M_AXI_RREADY;
            r_b_pend  <= M_AXI_BVALID  && !M_AXI_BREADY;
            r_ar_pay  <= w_ar_pay;
            r_aw_pay  <= w_aw_pay;
            r_w_pay   <= w_w_pay;
            r_r_pay   <= w_r_pay;
            r_b_pay   <= M_AXI_BRESP;
        end
    end

    // Burst-length FIFOs, matched in address-acceptance order.
    logic [7:0]    r_wr_fifo [MAX_OUTSTANDING];
    logic [7:0]    r_rd_fifo [MAX_OUTSTANDING];
    logic [PW-1:0] r_wr_wptr, r_wr_rptr, r_rd_wptr, r_rd_rptr;
    logic [CW-1:0] r_wr_cnt, r_rd_cnt, r_b_pending;
    logic [7:0]    r_w_idx, r_r_idx;

    logic       w_wr_empty, w_wr_full, w_rd_empty, w_rd_full;
    logic       w_wr_push, w_wr_pop, w_rd_push, w_rd_pop;
    logic [7:0] w_w_len, w_r_len;
    logic       w_w_beat, w_w_last, w_r_beat, w_r_last, w_b_dec;

    assign w_wr_empty = (r_wr_cnt == '0);
    assign w_wr_full  = (r_wr_cnt == CW'(MAX_OUTSTANDING));
    assign w_rd_empty = (r_rd_cnt == '0);
    assign w_rd_full  = (r_rd_cnt == CW'(MAX_OUTSTANDING));

    // An empty FIFO with a same-cycle AW takes the burst length straight from AWLEN.
    assign w_w_len   = w_wr_empty ? M_AXI_AWLEN : r_wr_fifo[r_wr_rptr];
    assign w_w_beat  = w_w_hs && (!w_wr_empty || w_aw_hs);
    assign w_w_last  = (r_w_idx == w_w_len);
    assign w_wr_push = w_aw_hs && !w_wr_full;
    assign w_wr_pop  = w_w_beat && w_w_last;

    assign w_r_len   = r_rd_fifo[r_rd_rptr];
    assign w_r_beat  = w_r_hs && !w_rd_empty;
    assign w_r_last  = (r_r_idx == w_r_len);
    assign w_rd_push = w_ar_hs && !w_rd_full;
    assign w_rd_pop  = w_r_beat && w_r_last;

    assign w_b_dec   = w_b_hs && (r_b_pending != '0);

    // NOTE: FIFO storage carries no reset; count and pointers alone define validity.
    always_ff @(posedge M_AXI_ACLK) begin
        if (w_wr_push) r_wr_fifo[r_wr_wptr] <= M_AXI_AWLEN;
        if (w_rd_push) r_rd_fifo[r_rd_wptr] <= M_AXI_ARLEN;
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_wr_wptr   <= '0;
            r_wr_rptr   <= '0;
            r_rd_wptr   <= '0;
            r_rd_rptr   <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_b_pending <= '0;
            r_w_idx     <= '0;
            r_r_idx     <= '0;
        end else begin
            if (w_wr_push) r_wr_wptr <= r_wr_wptr + 1'b1;
            if (w_wr_pop)  r_wr_rptr <= r_wr_rptr + 1'b1;
            if (w_rd_push) r_rd_wptr <= r_rd_wptr + 1'b1;
            if (w_rd_pop)  r_rd_rptr <= r_rd_rptr + 1'b1;

            if (w_wr_push && !w_wr_pop)      r_wr_cnt <= r_wr_cnt + 1'b1;
            else if (!w_wr_push && w_wr_pop) r_wr_cnt <= r_wr_cnt - 1'b1;
            if (w_rd_push && !w_rd_pop)      r_rd_cnt <= r_rd_cnt + 1'b1;
            else if (!w_rd_push && w_rd_pop) r_rd_cnt <= r_rd_cnt - 1'b1;

            if (w_wr_pop && !w_b_dec && r_b_pending != CW'(MAX_OUTSTANDING))
                r_b_pending <= r_b_pending + 1'b1;
            else if (!w_wr_pop && w_b_dec)
                r_b_pending <= r_b_pending - 1'b1;

            if (w_w_beat) r_w_idx <= w_w_last ? 8'd0 : r_w_idx + 8'd1;
            if (w_r_beat) r_r_idx <= w_r_last ? 8'd0 : r_r_idx + 8'd1;
        end
    end

    assign mon_wr_outstanding = OW'(r_wr_cnt) + OW'(r_b_pending);
    assign mon_rd_outstanding = OW'(r_rd_cnt);

    logic w_timeout;
`ifdef AXI_MON_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;
    logic          w_busy, w_any_hs;

    assign w_busy    = (mon_wr_outstanding != '0) || (mon_rd_outstanding != '0);
    assign w_any_hs  = w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;
    assign w_timeout = w_busy && !w_any_hs && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET)                           r_to_cnt <= '0;
        else if (!w_busy || w_any_hs)               r_to_cnt <= '0;
        else if (r_to_cnt != TW'(TIMEOUT_CYCLES))   r_to_cnt <= r_to_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    logic [16:0] w_err;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_err     = '0;
        w_err[0]  = r_ar_pend && !M_AXI_ARVALID;
        w_err[1]  = r_aw_pend && !M_AXI_AWVALID;
        w_err[2]  = r_w_pend  && !M_AXI_WVALID;
        w_err[3]  = r_r_pend  && !M_AXI_RVALID;
        w_err[4]  = r_b_pend  && !M_AXI_BVALID;
        w_err[5]  = r_ar_pend && M_AXI_ARVALID && (w_ar_pay != r_ar_pay);
        w_err[6]  = r_aw_pend && M_AXI_AWVALID && (w_aw_pay != r_aw_pay);
        w_err[7]  = r_w_pend  && M_AXI_WVALID  && (w_w_pay  != r_w_pay);
        w_err[8]  = r_r_pend  && M_AXI_RVALID  && (w_r_pay  != r_r_pay);
        w_err[9]  = r_b_pend  && M_AXI_BVALID  && (M_AXI_BRESP != r_b_pay);
        w_err[10] = w_w_hs && w_wr_empty && !w_aw_hs;
        w_err[11] = w_w_beat && (M_AXI_WLAST != w_w_last);
        w_err[12] = w_r_beat && (M_AXI_RLAST != w_r_last);
        w_err[13] = w_r_hs && w_rd_empty;
        w_err[14] = w_b_hs && (r_b_pending == '0);
        w_err[15] = (w_aw_hs && w_wr_full) || (w_ar_hs && w_rd_full);
        w_err[16] = w_timeout;
    end

    function automatic logic [4:0] first_code(input logic [16:0] err);
        logic [4:0] code;
        code = '0;
        for (int i = 16; i >= 0; i--)
            if (err[i]) code = 5'(i + 1);
        return code;
    endfunction

    logic [16:0] r_err;
    logic [4:0]  r_err_first;

    // A clear still records anything detected in the same cycle.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_err       <= '0;
            r_err_first <= '0;
        end else if (mon_err_clr) begin
            r_err       <= w_err;
            r_err_first <= first_code(w_err);
        end else begin
            r_err <= r_err | w_err;
            if (r_err_first == '0) r_err_first <= first_code(w_err);
        end
    end

    assign mon_err       = r_err;
    assign mon_err_first = r_err_first;
    assign mon_irq       = |r_err;

endmodule
